pattern_gen: RTL and testbench

- AXI4-Stream test-pattern source sitting directly upstream of the vga timing block; drives its pix_* input.
- Starts one frame per sof request from the vga block. Emits exactly h_res x v_res pixels in raster order, with tuser on the first pixel and tlast on the last pixel of each line.
- Four selectable patterns (colour bars, checkerboard, gradient, solid) for bring-up of the display path without a frame buffer.

---
 rtl/pattern_gen_if.sv | 25 ++
 rtl/pattern_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_pattern_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_if.sv
// AXI4-Stream pixel link between the pattern source and the vga timing block.
// The master drives pixels, the slave returns ready.
interface pattern_gen_if;
    logic        pix_tvalid;
    logic        pix_tready;
    logic [11:0] pix_tdata;
    logic        pix_tlast;
    logic        pix_tuser;

    modport master (
        output pix_tvalid,
        output pix_tdata,
        output pix_tlast,
        output pix_tuser,
        input  pix_tready
    );

    modport slave (
        input  pix_tvalid,
        input  pix_tdata,
        input  pix_tlast,
        input  pix_tuser,
        output pix_tready
    );
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern source for bring-up of the display path without a frame buffer.
// One frame of h_res x v_res pixels is streamed in raster order per accepted sof.
// Every output is a register; the pixel for the next coordinate is computed
// combinationally and loaded together with the coordinate on each transfer.
module pattern_gen #(
    parameter int unsigned CHECK_LOG2 = 4
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [15:0]   h_res,
    input  logic [15:0]   v_res,
    input  logic [1:0]    pattern_sel,
    input  logic [11:0]   solid_color,
    input  logic          sof,
    pattern_gen_if.master pix,
    output logic          busy,
    output logic          sof_overrun,
    output logic [7:0]    frame_cnt
);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;

    // Colour-bar tracking: bar index plus pixel count within the current bar,
    // so the bar boundary is found without dividing x by the bar width.
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;

    // Shadow copies of the configuration, frozen for the whole frame.
    logic [15:0] h_res_q, h_res_d;
    logic [15:0] v_res_q, v_res_d;
    logic [1:0]  pat_q, pat_d;
    logic [11:0] solid_q, solid_d;
    logic [15:0] bar_w_q, bar_w_d;

    logic        tvalid_q, tvalid_d;
    logic [11:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        sof_overrun_q, sof_overrun_d;

    logic        last_x;
    logic        last_y;
    logic [15:0] nx;
    logic [15:0] ny;
    logic [2:0]  nbar_idx;
    logic [15:0] nbar_cnt;

    // Pixel colour for a coordinate under the given pattern.
    function automatic logic [11:0] pattern_px(
        input logic [1:0]  pat,
        input logic [11:0] solid,
        input logic [15:0] px,
        input logic [15:0] py,
        input logic [2:0]  bar,
        input logic [7:0]  fcnt
    );
        logic [11:0] c;
        c = 12'h000;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    c = 12'hFFF;
                    3'd1:    c = 12'hFF0;
                    3'd2:    c = 12'h0FF;
                    3'd3:    c = 12'h0F0;
                    3'd4:    c = 12'hF0F;
                    3'd5:    c = 12'hF00;
                    3'd6:    c = 12'h00F;
                    default: c = 12'h000;
                endcase
            end
            2'd1:    c = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? 12'hFFF : 12'h000;
            2'd2:    c = {px[7:4], py[7:4], fcnt[3:0]};
            default: c = solid;
        endcase
        return c;
    endfunction

    assign last_x = (x_q == h_res_q - 16'd1);
    assign last_y = (y_q == v_res_q - 16'd1);

    // Next coordinate and bar position after a transfer of the current pixel.
    always_comb begin
        nx       = 16'd0;
        ny       = 16'd0;
        nbar_idx = 3'd0;
        nbar_cnt = 16'd0;
        if (last_x) begin
            ny = y_q + 16'd1;
        end else begin
            nx = x_q + 16'd1;
            ny = y_q;
            if (bar_cnt_q == bar_w_q - 16'd1) begin
                nbar_idx = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                nbar_idx = bar_idx_q;
                nbar_cnt = bar_cnt_q + 16'd1;
            end
        end
    end

    // FSM next state, frame start/advance/finish and output next values.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        bar_idx_d     = bar_idx_q;
        bar_cnt_d     = bar_cnt_q;
        h_res_d       = h_res_q;
        v_res_d       = v_res_q;
        pat_d         = pat_q;
        solid_d       = solid_q;
        bar_w_d       = bar_w_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        frame_cnt_d   = frame_cnt_q;
        sof_overrun_d = 1'b0;

        case (state_q)
            StIdle: begin
                // A zero-sized frame request is silently ignored.
                if (sof && (h_res != 16'd0) && (v_res != 16'd0)) begin
                    state_d   = StStream;
                    h_res_d   = h_res;
                    v_res_d   = v_res;
                    pat_d     = pattern_sel;
                    solid_d   = solid_color;
                    bar_w_d   = (h_res[15:3] == 13'd0) ? 16'd1 : {3'b000, h_res[15:3]};
                    x_d       = 16'd0;
                    y_d       = 16'd0;
                    bar_idx_d = 3'd0;
                    bar_cnt_d = 16'd0;
                    tvalid_d  = 1'b1;
                    tdata_d   = pattern_px(pattern_sel, solid_color, 16'd0, 16'd0, 3'd0,
                                           frame_cnt_q);
                    tuser_d   = 1'b1;
                    tlast_d   = (h_res == 16'd1);
                end
            end
            StStream: begin
                // Includes the completion cycle: a sof there is dropped too.
                sof_overrun_d = sof;
                if (tvalid_q && pix.pix_tready) begin
                    if (last_x && last_y) begin
                        state_d     = StIdle;
                        tvalid_d    = 1'b0;
                        tdata_d     = 12'h000;
                        tlast_d     = 1'b0;
                        tuser_d     = 1'b0;
                        x_d         = 16'd0;
                        y_d         = 16'd0;
                        bar_idx_d   = 3'd0;
                        bar_cnt_d   = 16'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        x_d       = nx;
                        y_d       = ny;
                        bar_idx_d = nbar_idx;
                        bar_cnt_d = nbar_cnt;
                        tdata_d   = pattern_px(pat_q, solid_q, nx, ny, nbar_idx, frame_cnt_q);
                        tlast_d   = (nx == h_res_q - 16'd1);
                        tuser_d   = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StIdle;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            bar_idx_q     <= 3'd0;
            bar_cnt_q     <= 16'd0;
            h_res_q       <= 16'd0;
            v_res_q       <= 16'd0;
            pat_q         <= 2'd0;
            solid_q       <= 12'h000;
            bar_w_q       <= 16'd1;
            tvalid_q      <= 1'b0;
            tdata_q       <= 12'h000;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            frame_cnt_q   <= 8'd0;
            sof_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            h_res_q       <= h_res_d;
            v_res_q       <= v_res_d;
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            bar_w_q       <= bar_w_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            frame_cnt_q   <= frame_cnt_d;
            sof_overrun_q <= sof_overrun_d;
        end
    end

    assign pix.pix_tvalid = tvalid_q;
    assign pix.pix_tdata  = tdata_q;
    assign pix.pix_tlast  = tlast_q;
    assign pix.pix_tuser  = tuser_q;
    assign busy           = (state_q == StStream);
    assign sof_overrun    = sof_overrun_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed frames plus randomized sizes, patterns and
// backpressure, checked against a raster-order reference model.
module tb_pattern_gen;
    localparam int unsigned CL = 4;

    logic        aclk;
    logic        areset;
    logic [15:0] h_res;
    logic [15:0] v_res;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_color;
    logic        sof;
    logic        busy;
    logic        sof_overrun;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int fc_model = 0;

    pattern_gen_if pix_if ();

    pattern_gen #(
        .CHECK_LOG2(CL)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .h_res      (h_res),
        .v_res      (v_res),
        .pattern_sel(pattern_sel),
        .solid_color(solid_color),
        .sof        (sof),
        .pix        (pix_if),
        .busy       (busy),
        .sof_overrun(sof_overrun),
        .frame_cnt  (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Colour of pixel (x, y) straight from the pattern definitions.
    function automatic logic [11:0] model_px(input int p, input int h, input int x, input int y,
                                             input logic [11:0] sol, input int fc);
        int bw;
        int idx;
        logic [11:0] c;
        c = 12'h000;
        case (p)
            0: begin
                bw  = ((h >> 3) == 0) ? 1 : (h >> 3);
                idx = x / bw;
                if (idx > 7) idx = 7;
                case (idx)
                    0: c = 12'hFFF;
                    1: c = 12'hFF0;
                    2: c = 12'h0FF;
                    3: c = 12'h0F0;
                    4: c = 12'hF0F;
                    5: c = 12'hF00;
                    6: c = 12'h00F;
                    default: c = 12'h000;
                endcase
            end
            1: c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 12'hFFF : 12'h000;
            2: begin
                c[11:8] = 4'(x >> 4);
                c[7:4]  = 4'(y >> 4);
                c[3:0]  = 4'(fc);
            end
            default: c = sol;
        endcase
        return c;
    endfunction

    // One requested frame; mid >= 0 pulses sof and scrambles the config when
    // that many beats have been delivered.
    task automatic run_frame(input int h, input int v, input int p, input logic [11:0] sol,
                             input int pct, input int mid);
        int n, beat, cyc, ovr, budget, bx, by;
        logic stalled, rdy, mid_done, sl, su;
        logic [11:0] sd;
        n = h * v;
        budget = 8 * n + 50;
        @(negedge aclk);
        h_res = 16'(h);
        v_res = 16'(v);
        pattern_sel = 2'(p);
        solid_color = sol;
        sof = 1'b1;
        pix_if.pix_tready = 1'b0;
        @(negedge aclk);
        sof = 1'b0;
        chk("start_tvalid", 32'(pix_if.pix_tvalid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        beat = 0; cyc = 0; ovr = 0; stalled = 1'b0; mid_done = 1'b0;
        sd = 12'h000; sl = 1'b0; su = 1'b0;
        while (beat < n && cyc < budget) begin
            sof = 1'b0;
            if (sof_overrun) ovr++;
            chk("tvalid_hold", 32'(pix_if.pix_tvalid), 32'd1);
            if (stalled) begin
                chk("stall_data", 32'(pix_if.pix_tdata), 32'(sd));
                chk("stall_last", 32'(pix_if.pix_tlast), 32'(sl));
                chk("stall_user", 32'(pix_if.pix_tuser), 32'(su));
            end
            rdy = ($urandom_range(0, 99) < pct);
            pix_if.pix_tready = rdy;
            if (rdy) begin
                bx = beat % h;
                by = beat / h;
                chk("px_data", 32'(pix_if.pix_tdata), 32'(model_px(p, h, bx, by, sol, fc_model)));
                chk("px_user", 32'(pix_if.pix_tuser), 32'(bx == 0 && by == 0));
                chk("px_last", 32'(pix_if.pix_tlast), 32'(bx == h - 1));
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                sd = pix_if.pix_tdata;
                sl = pix_if.pix_tlast;
                su = pix_if.pix_tuser;
            end
            if (!mid_done && mid >= 0 && beat >= mid && beat < n) begin
                sof = 1'b1;
                pattern_sel = 2'(p + 1);
                h_res = 16'(h + 3);
                v_res = 16'(v + 1);
                solid_color = ~sol;
                mid_done = 1'b1;
            end
            @(negedge aclk);
            cyc++;
        end
        sof = 1'b0;
        if (sof_overrun) ovr++;
        chk("beats", 32'(beat), 32'(n));
        chk("end_tvalid", 32'(pix_if.pix_tvalid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        fc_model = (fc_model + 1) % 256;
        chk("frame_cnt", 32'(frame_cnt), 32'(fc_model));
        @(negedge aclk);
        if (sof_overrun) ovr++;
        chk("no_restart", 32'(pix_if.pix_tvalid), 32'd0);
        chk("overrun_pulses", 32'(ovr), (mid >= 0) ? 32'd1 : 32'd0);
    endtask

    // A zero-sized request must be ignored.
    task automatic zero_frame(input int h, input int v);
        @(negedge aclk);
        h_res = 16'(h);
        v_res = 16'(v);
        sof = 1'b1;
        @(negedge aclk);
        sof = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("zero_tvalid", 32'(pix_if.pix_tvalid), 32'd0);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_overrun", 32'(sof_overrun), 32'd0);
            @(negedge aclk);
        end
    endtask

    initial begin
        int h, v, n, mid;
        areset = 1'b1;
        sof = 1'b0;
        h_res = 16'd4;
        v_res = 16'd2;
        pattern_sel = 2'd0;
        solid_color = 12'h000;
        pix_if.pix_tready = 1'b1;

        // Reset state.
        repeat (2) @(negedge aclk);
        chk("rst_tvalid", 32'(pix_if.pix_tvalid), 32'd0);
        chk("rst_tdata", 32'(pix_if.pix_tdata), 32'd0);
        chk("rst_tlast", 32'(pix_if.pix_tlast), 32'd0);
        chk("rst_tuser", 32'(pix_if.pix_tuser), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(sof_overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        areset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("idle_tvalid", 32'(pix_if.pix_tvalid), 32'd0);
        end

        run_frame(4, 2, 1, 12'h000, 100, -1);
        run_frame(16, 1, 0, 12'h000, 100, -1);
        run_frame(16, 1, 2, 12'h000, 50, -1);
        run_frame(12, 3, 3, 12'h5A3, 70, 17);
        run_frame(5, 2, 0, 12'h000, 100, 9);
        zero_frame(0, 3);
        zero_frame(7, 0);

        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(1, 40));
            v = int'($urandom_range(1, 12));
            n = h * v;
            mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            run_frame(h, v, int'($urandom_range(0, 3)), 12'($urandom), int'($urandom_range(30, 100)),
                      mid);
        end

        // Single-pixel frames up to and through the frame counter wrap.
        while (fc_model != 0) begin
            run_frame(1, 1, int'($urandom_range(0, 3)), 12'($urandom), 100, -1);
        end

        // Reset in the middle of a frame.
        @(negedge aclk);
        h_res = 16'd8;
        v_res = 16'd4;
        pattern_sel = 2'd1;
        sof = 1'b1;
        pix_if.pix_tready = 1'b1;
        @(negedge aclk);
        sof = 1'b0;
        repeat (10) @(negedge aclk);
        chk("mid_busy", 32'(busy), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        fc_model = 0;
        chk("mrst_tvalid", 32'(pix_if.pix_tvalid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge aclk);
        chk("mrst_stays_idle", 32'(pix_if.pix_tvalid), 32'd0);
        run_frame(8, 4, 2, 12'h000, 60, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
